interp_filt_ctrl: RTL
=====================

Name: interp_filt_ctrl

Overview:
Phase sequencer for one interp_filt_tap_1 datapath. It accepts one input sample per handshake and replays it through the tap once per interpolation phase, selecting a per-phase tap coefficient from a writable coefficient bank. It returns L output samples per input on a valid/ready output port, with the last one flagged. It sits between the upstream sample source and the downstream consumer, and owns the tap's in, tap_coeff and enable.

Parameters:
DATA_WIDTH, 6, width of signed sample data (tap in/out, s_data, m_data)
TAP_COEFF_WIDTH, 6, width of signed tap coefficient
MAX_L, 4, maximum interpolation factor; coefficient bank depth
PIPE_LAT, 1, tap datapath latency in cycles (>=1)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, asynchronous, active-low
cfg_we  in  1  coefficient bank write enable
cfg_addr  in  $clog2(MAX_L)  coefficient bank write address (phase index)
cfg_coeff  in  TAP_COEFF_WIDTH  coefficient write data
cfg_l  in  $clog2(MAX_L)+1  interpolation factor L, sampled at input accept
s_valid  in  1  input sample valid
s_ready  out  1  controller can accept a sample
s_data  in  DATA_WIDTH  input sample
tap_in  out  DATA_WIDTH  to tap `in`
tap_coeff  out  TAP_COEFF_WIDTH  to tap `tap_coeff`
tap_en  out  1  one-cycle issue strobe (tap result valid PIPE_LAT cycles later)
tap_out  in  DATA_WIDTH  from tap `out`
m_valid  out  1  output sample valid
m_ready  in  1  downstream accepts output
m_data  out  DATA_WIDTH  output sample
m_last  out  1  m_data is phase L-1 of current input
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, phase=0, sample reg=0, L reg=1, all coefficient entries=0, wait counter=0; s_ready=1, tap_en=0, tap_in=0, tap_coeff=0, m_valid=0, m_data=0, m_last=0, busy=0.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - s_ready=1.
  - On s_valid&&s_ready: latch s_data, latch L=cfg_l, phase=0, go to ISSUE.
  - cfg_l of 0 or >MAX_L latches as MAX_L.
- ISSUE (1 cycle):
  - tap_en=1, tap_in=sample reg, tap_coeff=coeff[phase].
  - Load wait counter with PIPE_LAT, go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter reaches 1 (the PIPE_LAT-th WAIT cycle), register tap_out into m_data and set m_last=(phase==L-1).
  - Go to OUT.
- OUT:
  - m_valid=1; m_data and m_last held stable until m_ready.
  - On m_valid&&m_ready with phase==L-1: go to IDLE; m_valid=0 and s_ready=1 next cycle.
  - On m_valid&&m_ready otherwise: phase+=1, go to ISSUE.
- tap_in and tap_coeff are registered/held outside ISSUE. Only tap_en qualifies them.
- s_ready=0 in every state except IDLE. There is no input buffering.
- Latency (PIPE_LAT=1, m_ready=1):
  - Accept edge at cycle 0, ISSUE in cycle 1, WAIT in cycle 2, first m_valid in cycle 3.
  - Per-phase period is PIPE_LAT+2 cycles.
  - Input period is L*(PIPE_LAT+2)+1 cycles.
- Coefficient bank:
  - Register array; write on cfg_we at any time.
  - A write to the address being read in the same ISSUE cycle is not seen: the old value is issued. The new value applies to later issues.
- Backpressure: m_ready low holds OUT indefinitely. No new tap_en is issued while stalled.
- No arithmetic in the controller. m_data is tap_out bit-for-bit.
- Reset asserted mid-operation aborts the sequence immediately. The pending sample and outputs are discarded. Coefficients return to 0.

Test Plan:
- Reset values: hold rst=0 for 2 cycles, release → s_ready=1, m_valid=0, tap_en=0, busy=0, m_data=0. The bench tap model is tap_out = (tap_in + tap_coeff) mod 2^6, delayed PIPE_LAT cycles.
- Basic L=4: write coeff {1,2,3,4}, cfg_l=4, send s_data=5, m_ready=1 → m_data 6,7,8,9 with m_last only on 9; first m_valid 3 cycles after accept; s_ready returns 1 cycle after the 4th handshake; tap_en pulses exactly 4 times.
- Backpressure: as above but m_ready=0 for 5 cycles on phase 1 → m_data=7 held stable, no tap_en during the stall, sequence then resumes as 8,9.
- Clamp and L=1: cfg_l=0 → 4 outputs; cfg_l=1, coeff[0]=-1, s_data=0 → single output -1 (6'h3F) with m_last=1.
- Coefficient write collision: cfg_we to addr 1 with value 10 in the same cycle as phase-1 ISSUE → the old coeff is used; the next input uses 10.
- Reset mid-sequence: drop rst during WAIT of phase 2 → all outputs at reset values immediately; after release, new s_data=0 with cfg_l=2 → outputs 0,0 (coeffs cleared).

Source files
------------

// File: rtl/interp_filt_ctrl.sv
// interp_filt_ctrl: phase sequencer for one interpolation tap.
// Replays each accepted sample through the tap once per phase.
// Ports: clk/rst; cfg_* coefficient bank write and L select;
// s_* input stream; tap_* datapath drive and return;
// m_* output stream (m_last marks phase L-1); busy when not idle.
module interp_filt_ctrl #(
   parameter int DATA_WIDTH      = 6,
   parameter int TAP_COEFF_WIDTH = 6,
   parameter int MAX_L           = 4,
   parameter int PIPE_LAT        = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cfg_we,
   input  logic [$clog2(MAX_L)-1:0]     cfg_addr,
   input  logic [TAP_COEFF_WIDTH-1:0]   cfg_coeff,
   input  logic [$clog2(MAX_L):0]       cfg_l,
   input  logic                         s_valid,
   output logic                         s_ready,
   input  logic [DATA_WIDTH-1:0]        s_data,
   output logic [DATA_WIDTH-1:0]        tap_in,
   output logic [TAP_COEFF_WIDTH-1:0]   tap_coeff,
   output logic                         tap_en,
   input  logic [DATA_WIDTH-1:0]        tap_out,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic [DATA_WIDTH-1:0]        m_data,
   output logic                         m_last,
   output logic                         busy
);

   localparam int AW = $clog2(MAX_L);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(PIPE_LAT + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] OUT   = 2'd3;

   logic [1:0]                 state;
   logic [AW-1:0]              phase;
   logic [DATA_WIDTH-1:0]      samp;
   logic [DATA_WIDTH-1:0]      tin_q;
   logic [TAP_COEFF_WIDTH-1:0] tcf_q;
   logic [TAP_COEFF_WIDTH-1:0] coef [MAX_L];
   logic [LW-1:0]              lreg;
   logic [LW-1:0]              lclamp;
   logic [LW-1:0]              lm1;
   logic [CW-1:0]              wcnt;
   logic                       last_ph;

   // Out-of-range L requests fall back to the full bank depth.
   always_comb begin
      lclamp = cfg_l;
      if (cfg_l == '0 || cfg_l > LW'(MAX_L))
         lclamp = LW'(MAX_L);
   end

   assign lm1     = lreg - LW'(1);
   assign last_ph = ({1'b0, phase} == lm1);

   assign s_ready = (state == IDLE);
   assign busy    = (state != IDLE);
   assign tap_en  = (state == ISSUE);
   assign m_valid = (state == OUT);

   // Live values only during ISSUE; otherwise the last issued
   // operands are held so bank writes never disturb the tap.
   assign tap_in    = tap_en ? samp        : tin_q;
   assign tap_coeff = tap_en ? coef[phase] : tcf_q;

   // Bank writes land at the clock edge, so an ISSUE that reads
   // the same entry in that cycle still sees the old value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < MAX_L; i++)
            coef[i] <= '0;
      end else if (cfg_we) begin
         coef[cfg_addr] <= cfg_coeff;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         phase  <= '0;
         samp   <= '0;
         lreg   <= LW'(1);
         wcnt   <= '0;
         tin_q  <= '0;
         tcf_q  <= '0;
         m_data <= '0;
         m_last <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (s_valid) begin
                  samp  <= s_data;
                  lreg  <= lclamp;
                  phase <= '0;
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               tin_q <= samp;
               tcf_q <= coef[phase];
               wcnt  <= CW'(PIPE_LAT);
               state <= WAIT;
            end
            WAIT: begin
               wcnt <= wcnt - CW'(1);
               if (wcnt == CW'(1)) begin
                  m_data <= tap_out;
                  m_last <= last_ph;
                  state  <= OUT;
               end
            end
            OUT: begin
               if (m_ready) begin
                  if (last_ph) begin
                     state <= IDLE;
                  end else begin
                     phase <= phase + AW'(1);
                     state <= ISSUE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
